// File: rtl/alu_mul_sequencer_if.sv
// Command and shared-ALU signals of the multiply sequencer.
// The master modport is the sequencer's view; slave is the environment (requester, arbiter, ALU).
interface alu_mul_sequencer_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic       alu_req;
    logic       alu_gnt;
    logic [2:0] alu_op;
    logic [7:0] alu_reg;
    logic [7:0] alu_acc;
    logic [7:0] alu_rslt;

    modport master (
        input  start, a, b, alu_gnt, alu_rslt,
        output busy, done, product, alu_req, alu_op, alu_reg, alu_acc
    );

    modport slave (
        output start, a, b, alu_gnt, alu_rslt,
        input  busy, done, product, alu_req, alu_op, alu_reg, alu_acc
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// 8x8 (mod 256) shift-add multiplier that runs its steps through the shared accumulator ALU.
// Define MUL_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    alu_mul_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADD, S_SHL, S_SHR, S_DONE
    } state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;

    state_e     state_q, state_d;
    logic [7:0] p_q, p_d;
    logic [7:0] m_q, m_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;

    logic       alu_req;
    logic [2:0] alu_op;
    logic [7:0] alu_reg;
    logic [7:0] alu_acc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            p_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            m_q       <= m_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        m_d       = m_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        alu_req   = 1'b0;
        alu_op    = OP_ADD;
        alu_reg   = '0;
        alu_acc   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                alu_req = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
                if (q_q == 8'd0) begin
                    product_d = '0;
                    state_d   = S_DONE;
                end else if (bus.alu_gnt) begin
                    state_d = S_ADD;
                end
`else
                if (bus.alu_gnt) state_d = S_ADD;
`endif
            end
            // ALU steps keep their operands on the bus while the grant is away and simply retry.
            S_ADD: begin
                alu_req = 1'b1;
                alu_op  = OP_ADD;
                alu_reg = p_q;
                alu_acc = m_q;
                if (bus.alu_gnt) begin
                    if (q_q[0]) p_d = bus.alu_rslt;
                    state_d = S_SHL;
                end
            end
            S_SHL: begin
                alu_req = 1'b1;
                alu_op  = OP_SLL;
                alu_reg = 8'd1;
                alu_acc = m_q;
                if (bus.alu_gnt) begin
                    m_d     = bus.alu_rslt;
                    state_d = S_SHR;
                end
            end
            S_SHR: begin
                alu_req = 1'b1;
                alu_op  = OP_SRL;
                alu_reg = 8'd1;
                alu_acc = q_q;
                if (bus.alu_gnt) begin
                    q_d   = bus.alu_rslt;
                    cnt_d = cnt_q + 3'd1;
`ifdef MUL_EARLY_EXIT_EN
                    if (cnt_q == 3'd7 || bus.alu_rslt == 8'd0) begin
`else
                    if (cnt_q == 3'd7) begin
`endif
                        product_d = p_q;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.alu_req = alu_req;
    assign bus.alu_op  = alu_op;
    assign bus.alu_reg = alu_reg;
    assign bus.alu_acc = alu_acc;
    assign bus.busy    = (state_q == S_REQ) || (state_q == S_ADD) ||
                         (state_q == S_SHL) || (state_q == S_SHR);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule
